jesd207_burst_ctrl: RTL and testbench



---
 rtl/jesd207_pkg.sv | 21 ++
 rtl/jesd207_burst_ctrl_if.sv | 42 ++++
 rtl/jesd207_guard_timer.sv | 29 ++
 rtl/jesd207_burst_ctrl.sv | 156 +++++++++++++++
 tb/tb_jesd207_burst_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/jesd207_pkg.sv
// Shared types and constants for the JESD207 burst controller.
// State encoding, ENABLE mode selectors and default guard times.
package jesd207_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_TRANS = 3'd2,
    S_STOP  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam int EN_PULSE = 0;
  localparam int EN_LEVEL = 1;

  localparam int DEF_SETUP_CYC = 3;
  localparam int DEF_GAP_CYC   = 2;

  localparam int GUARD_W = 8;

endpackage

// File: rtl/jesd207_burst_ctrl_if.sv
// Host/FIFO-side bundle of the JESD207 burst controller.
// master = host and FIFO flags, slave = controller.
interface jesd207_burst_ctrl_if #(
  parameter int LENW = 16
);

  logic            start;
  logic            tx_nrx_req;
  logic [LENW-1:0] burst_len;
  logic            abort;
  logic            fifo_rempty;
  logic            fifo_wfull;
  logic            fifo_rd_en;
  logic            fifo_wr_en;
  logic            tx_nrx;
  logic            jesd_en;
  logic            ch_id;
  logic            busy;
  logic            done;
  logic [LENW-1:0] xfer_cnt;
  logic            short_burst;
  logic            aborted;

  modport master (
    output start, tx_nrx_req, burst_len, abort,
    output fifo_rempty, fifo_wfull,
    input  fifo_rd_en, fifo_wr_en,
    input  tx_nrx, jesd_en, ch_id,
    input  busy, done, xfer_cnt,
    input  short_burst, aborted
  );

  modport slave (
    input  start, tx_nrx_req, burst_len, abort,
    input  fifo_rempty, fifo_wfull,
    output fifo_rd_en, fifo_wr_en,
    output tx_nrx, jesd_en, ch_id,
    output busy, done, xfer_cnt,
    output short_burst, aborted
  );

endinterface

// File: rtl/jesd207_guard_timer.sv
// Loadable down-counter with terminal flag.
// Shared by the SETUP and GAP guard intervals.
module jesd207_guard_timer
  import jesd207_pkg::*;
#(
  parameter int W = GUARD_W
) (
  input  logic         fclk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge fclk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/jesd207_burst_ctrl.sv
// JESD207 TXNRX/ENABLE burst sequencer gating an external FIFO.
// IDLE -> SETUP -> TRANS -> STOP -> GAP, with abort and status.
module jesd207_burst_ctrl
  import jesd207_pkg::*;
#(
  parameter int NCH         = 1,
  parameter int LENW        = 16,
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC,
  parameter int ENABLE_MODE = EN_PULSE
) (
  input logic           fclk,
  input logic           rstn,
  jesd207_burst_ctrl_if.slave bus
);

  localparam logic [GUARD_W-1:0] SETUP_LD =
    GUARD_W'(SETUP_CYC - 1);
  localparam logic [GUARD_W-1:0] GAP_LD =
    GUARD_W'(GAP_CYC - 1);

  state_t            state;
  state_t            state_n;
  logic [LENW-1:0]   len_q;
  logic [LENW-1:0]   cnt_q;
  logic [LENW-1:0]   cnt_inc;
  logic              tx_q;
  logic              en_q;
  logic              ch_q;
  logic              done_q;
  logic              short_q;
  logic              ab_q;
  logic              trans;
  logic              beat;
  logic              last_beat;
  logic              flag_stop;
  logic              ld;
  logic [GUARD_W-1:0] ld_val;
  logic              zero;
  logic              en_n;
  logic              done_n;

  jesd207_guard_timer #(.W(GUARD_W)) u_guard (
    .fclk  (fclk),
    .rstn  (rstn),
    .load  (ld),
    .value (ld_val),
    .zero  (zero)
  );

  assign trans = (state == S_TRANS);

  assign bus.fifo_rd_en = trans & tx_q & ~bus.fifo_rempty;
  assign bus.fifo_wr_en = trans & ~tx_q & ~bus.fifo_wfull;

  assign beat      = bus.fifo_rd_en | bus.fifo_wr_en;
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign last_beat = beat && (len_q != '0) && (cnt_inc == len_q);
  assign flag_stop = tx_q ? bus.fifo_rempty : bus.fifo_wfull;

  always_comb begin
    state_n = state;
    ld      = 1'b0;
    ld_val  = SETUP_LD;
    done_n  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_n = S_SETUP;
          ld      = 1'b1;
        end
      end
      S_SETUP: begin
        if (bus.abort) begin
          state_n = S_GAP;
          ld      = 1'b1;
          ld_val  = GAP_LD;
          done_n  = 1'b1;
        end else if (zero) begin
          state_n = S_TRANS;
        end
      end
      S_TRANS: begin
        if (last_beat || bus.abort || flag_stop) begin
          state_n = S_STOP;
          done_n  = 1'b1;
        end
      end
      S_STOP: begin
        state_n = S_GAP;
        ld      = 1'b1;
        ld_val  = GAP_LD;
      end
      S_GAP: begin
        if (zero) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // Pulse: high entering TRANS and in STOP. Level: high all TRANS.
    en_n =
      ((state_n == S_TRANS) &&
       ((state == S_SETUP) || (ENABLE_MODE == EN_LEVEL))) ||
      ((state_n == S_STOP) && (ENABLE_MODE == EN_PULSE));
  end

  always_ff @(posedge fclk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      en_q    <= 1'b0;
      ch_q    <= 1'b0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      ab_q    <= 1'b0;
    end else begin
      state  <= state_n;
      en_q   <= en_n;
      done_q <= done_n;
      if ((state == S_IDLE) && bus.start) begin
        len_q   <= bus.burst_len;
        tx_q    <= bus.tx_nrx_req;
        cnt_q   <= '0;
        ch_q    <= 1'b0;
        short_q <= 1'b0;
        ab_q    <= 1'b0;
      end
      if ((state == S_SETUP) && bus.abort) ab_q <= 1'b1;
      if (trans) begin
        if (beat) begin
          cnt_q <= cnt_inc;
          ch_q  <= (NCH == 2) ? ~ch_q : 1'b0;
        end
        // A completing beat wins over abort and flag stops.
        if (!last_beat) begin
          if (bus.abort) begin
            ab_q <= 1'b1;
          end else if (flag_stop && (len_q != '0)) begin
            short_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.tx_nrx      = tx_q;
  assign bus.jesd_en     = en_q;
  assign bus.ch_id       = ch_q;
  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = done_q;
  assign bus.xfer_cnt    = cnt_q;
  assign bus.short_burst = short_q;
  assign bus.aborted     = ab_q;

endmodule

// File: tb/tb_jesd207_burst_ctrl.sv
// Scoreboard bench: pulse/NCH=2 and level/NCH=1 controllers
// driven by the same host stimulus, each with its own FIFO model.
module tb_jesd207_burst_ctrl;
  import jesd207_pkg::*;

  typedef struct {
    int cnt;
    bit sh;
    bit ab;
    bit tx;
    int en0;
    int en1;
  } exp_t;

  logic fclk = 1'b0;
  logic rstn = 1'b1;
  always #5 fclk = ~fclk;

  logic        start = 1'b0;
  logic        txr   = 1'b1;
  logic        abrt  = 1'b0;
  logic [15:0] len   = '0;

  logic fld   = 1'b0;
  int   fld_l = 0;
  int   fld_c = 32;
  int   lvl0  = 0;
  int   lvl1  = 0;
  int   cap   = 32;

  jesd207_burst_ctrl_if #(.LENW(16)) b0 ();
  jesd207_burst_ctrl_if #(.LENW(16)) b1 ();

  assign b0.start       = start;
  assign b0.tx_nrx_req  = txr;
  assign b0.burst_len   = len;
  assign b0.abort       = abrt;
  assign b0.fifo_rempty = (lvl0 == 0);
  assign b0.fifo_wfull  = (lvl0 >= cap);
  assign b1.start       = start;
  assign b1.tx_nrx_req  = txr;
  assign b1.burst_len   = len;
  assign b1.abort       = abrt;
  assign b1.fifo_rempty = (lvl1 == 0);
  assign b1.fifo_wfull  = (lvl1 >= cap);

  jesd207_burst_ctrl #(
    .NCH(2), .LENW(16), .SETUP_CYC(3),
    .GAP_CYC(2), .ENABLE_MODE(EN_PULSE)
  ) u0 (
    .fclk(fclk), .rstn(rstn), .bus(b0)
  );

  jesd207_burst_ctrl #(
    .NCH(1), .LENW(16), .SETUP_CYC(3),
    .GAP_CYC(2), .ENABLE_MODE(EN_LEVEL)
  ) u1 (
    .fclk(fclk), .rstn(rstn), .bus(b1)
  );

  always @(posedge fclk) begin
    if (fld) begin
      lvl0 <= fld_l;
      lvl1 <= fld_l;
      cap  <= fld_c;
    end else begin
      if (b0.fifo_rd_en) lvl0 <= lvl0 - 1;
      if (b0.fifo_wr_en) lvl0 <= lvl0 + 1;
      if (b1.fifo_rd_en) lvl1 <= lvl1 - 1;
      if (b1.fifo_wr_en) lvl1 <= lvl1 + 1;
    end
  end

  exp_t q0[$];
  exp_t q1[$];
  exp_t cur[2];
  int   t[2];
  int   beats[2];
  int   ency[2];
  int   fen[2];
  int   fbeat[2];
  bit   pbusy[2];
  bit   act[2];
  bit   dseen[2];
  int   nvec = 0;
  int   nerr = 0;
  bit   end_req = 1'b0;
  bit   end_ack = 1'b0;

  task automatic chk(input string nm, input int d,
                     input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s dut%0d @%0t: got %0d expected %0d",
               nm, d, $time, got, exp);
    end
  endtask

  task automatic rstchk(input int d, input logic tx,
      input logic en, input logic ch, input logic busy,
      input logic done, input logic sh, input logic ab,
      input logic rd, input logic wr, input logic [15:0] cnt);
    chk("reset_state", d,
        int'({tx, en, ch, busy, done, sh, ab, rd, wr, cnt}),
        int'(25'h100_0000));
    pbusy[d] = 1'b0;
    act[d]   = 1'b0;
    dseen[d] = 1'b0;
  endtask

  task automatic mon(input int d, input logic busy,
      input logic done, input logic en, input logic rd,
      input logic wr, input logic ch, input logic tx,
      input logic sh, input logic ab, input logic [15:0] cnt);
    int exp_en;
    if (busy && !pbusy[d]) begin
      t[d] = 1; beats[d] = 0; ency[d] = 0;
      fen[d] = 0; fbeat[d] = 0; dseen[d] = 1'b0;
      if ((d == 0 ? q0.size() : q1.size()) == 0) begin
        chk("unexpected_start", d, 1, 0);
        act[d] = 1'b0;
      end else begin
        cur[d] = (d == 0) ? q0.pop_front() : q1.pop_front();
        act[d] = 1'b1;
      end
    end else if (busy) begin
      t[d]++;
    end
    pbusy[d] = busy;
    if (!busy) chk("idle_quiet", d, int'({en, rd, wr, done}), 0);
    if (busy && act[d]) begin
      chk("tx_nrx_hold", d, int'(tx), int'(cur[d].tx));
      if (dseen[d]) begin
        chk("gap_quiet", d, int'({en, rd, wr, done}), 0);
      end else begin
        if (rd || wr) begin
          if (fbeat[d] == 0) fbeat[d] = t[d];
          chk("beat_dir", d, int'(rd), int'(cur[d].tx));
          chk("ch_id_beat", d, int'(ch),
              (d == 0) ? beats[d] % 2 : 0);
          beats[d]++;
        end
        if (en) begin
          ency[d]++;
          if (fen[d] == 0) fen[d] = t[d];
        end
        if (done) begin
          exp_en = (d == 0) ? cur[d].en0 : cur[d].en1;
          chk("xfer_cnt", d, int'(cnt), cur[d].cnt);
          chk("beats", d, beats[d], cur[d].cnt);
          chk("short_burst", d, int'(sh), int'(cur[d].sh));
          chk("aborted", d, int'(ab), int'(cur[d].ab));
          chk("jesd_en_cycles", d, ency[d], exp_en);
          chk("jesd_en_first", d, fen[d], (exp_en > 0) ? 4 : 0);
          chk("beat_first", d, fbeat[d], (cur[d].cnt > 0) ? 4 : 0);
          chk("ch_id_end", d, int'(ch),
              (d == 0) ? cur[d].cnt % 2 : 0);
          dseen[d] = 1'b1;
        end
      end
      if (t[d] == 101) chk("busy_timeout", d, t[d], 100);
    end
  endtask

  always @(negedge fclk) begin
    if (!rstn) begin
      rstchk(0, b0.tx_nrx, b0.jesd_en, b0.ch_id, b0.busy,
             b0.done, b0.short_burst, b0.aborted,
             b0.fifo_rd_en, b0.fifo_wr_en, b0.xfer_cnt);
      rstchk(1, b1.tx_nrx, b1.jesd_en, b1.ch_id, b1.busy,
             b1.done, b1.short_burst, b1.aborted,
             b1.fifo_rd_en, b1.fifo_wr_en, b1.xfer_cnt);
    end else begin
      mon(0, b0.busy, b0.done, b0.jesd_en, b0.fifo_rd_en,
          b0.fifo_wr_en, b0.ch_id, b0.tx_nrx,
          b0.short_burst, b0.aborted, b0.xfer_cnt);
      mon(1, b1.busy, b1.done, b1.jesd_en, b1.fifo_rd_en,
          b1.fifo_wr_en, b1.ch_id, b1.tx_nrx,
          b1.short_burst, b1.aborted, b1.xfer_cnt);
    end
    if (end_req && !end_ack) begin
      chk("queue_left", 0, q0.size(), 0);
      chk("queue_left", 1, q1.size(), 0);
      chk("missing_done", 0, int'(act[0] && !dseen[0]), 0);
      chk("missing_done", 1, int'(act[1] && !dseen[1]), 0);
      end_ack = 1'b1;
    end
  end

  task automatic push(input int cnt, input bit sh, input bit ab,
                      input bit tx, input int en0, input int en1);
    exp_t e;
    e.cnt = cnt; e.sh = sh; e.ab = ab;
    e.tx = tx; e.en0 = en0; e.en1 = en1;
    q0.push_back(e);
    q1.push_back(e);
  endtask

  // Returns mid-way through the first SETUP cycle.
  task automatic go(input bit tx, input int l,
                    input int fl, input int fc);
    @(negedge fclk);
    fld = 1'b1; fld_l = fl; fld_c = fc;
    @(negedge fclk);
    fld = 1'b0; start = 1'b1; txr = tx; len = 16'(l);
    @(negedge fclk);
    start = 1'b0;
  endtask

  task automatic burst(input bit tx, input int l, input int fl,
      input int fc, input int cnt, input bit sh, input bit ab,
      input int en0, input int en1, input int abc);
    push(cnt, sh, ab, tx, en0, en1);
    go(tx, l, fl, fc);
    if (abc > 0) begin
      repeat (abc - 1) @(negedge fclk);
      abrt = 1'b1;
      @(negedge fclk);
      abrt = 1'b0;
    end
    repeat (30) @(negedge fclk);
  endtask

  initial begin
    #1 rstn = 1'b0;
    repeat (3) @(posedge fclk);
    #2 rstn = 1'b1;
    // tx len fill cap | cnt sh ab en_pulse en_level | abort_cycle
    burst(1, 8, 20, 32,  8, 0, 0, 2, 8, 0);
    burst(0, 0, 27, 32,  5, 0, 0, 2, 6, 0);
    burst(1, 10, 4, 32,  4, 1, 0, 2, 5, 0);
    burst(1, 6, 20, 32,  6, 0, 0, 2, 6, 0);
    burst(1, 8, 20, 32,  0, 0, 1, 0, 0, 2);
    burst(1, 4, 20, 32,  4, 0, 0, 2, 4, 7);
    burst(1, 0, 20, 32,  3, 0, 1, 2, 3, 6);
    burst(0, 3, 0, 32,   3, 0, 0, 2, 3, 0);
    // start in GAP is dropped; start in the following IDLE is taken
    push(2, 0, 0, 1, 2, 2);
    go(1, 2, 20, 32);
    repeat (6) @(negedge fclk);
    start = 1'b1; txr = 1'b0; len = 16'd2;
    @(negedge fclk);
    start = 1'b0;
    push(2, 0, 0, 0, 2, 2);
    @(negedge fclk);
    start = 1'b1;
    @(negedge fclk);
    start = 1'b0;
    repeat (30) @(negedge fclk);
    // reset asserted inside the third TRANS cycle
    push(0, 0, 0, 1, 0, 0);
    go(1, 0, 20, 32);
    repeat (4) @(negedge fclk);
    @(posedge fclk);
    #2 rstn = 1'b0;
    repeat (2) @(posedge fclk);
    #2 rstn = 1'b1;
    repeat (5) @(negedge fclk);
    burst(1, 3, 20, 32,  3, 0, 0, 2, 3, 0);
    end_req = 1'b1;
    for (int i = 0; i < 5 && !end_ack; i++) @(negedge fclk);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
